tour_cmd: RTL
=============

Name: tour_cmd

Overview:
- Sits between tour_logic (upstream; supplies the solved move sequence) and cmd_proc (downstream; executes motion commands).
- While idle, passes UART commands from RemoteComm/UART_wrapper straight through to cmd_proc.
- After start_tour, steps through the solved moves. Each one-hot knight move becomes two motion commands: vertical leg first, then horizontal leg.
- Sequences the cmd_rdy / clr_cmd_rdy / send_resp handshakes and supplies the response byte.

Parameters:
- NUM_MOVES, 24, number of moves in a 5x5 tour after the start square.
- IDX_W, 5, width of mv_indx.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start_tour  in  1  one-cycle pulse from cmd_proc; tour solution is ready
- move  in  8  one-hot move from tour_logic, addressed by mv_indx
- mv_indx  out  IDX_W  index of the current move, to tour_logic
- cmd_UART  in  16  command from UART_wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy_UART  out  1  clears UART cmd_rdy
- clr_cmd_rdy  in  1  from cmd_proc; command accepted
- send_resp  in  1  from cmd_proc; current command finished
- cmd  out  16  command to cmd_proc
- cmd_rdy  out  1  command valid to cmd_proc
- resp  out  8  response byte to UART_wrapper

Behaviour:
- Reset (synchronous, rst_n low at posedge clk):
  - state=IDLE, mv_indx=0.
  - Outputs therefore follow IDLE muxing: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, resp=8'hA5.
  - Reset mid-tour aborts the tour immediately.
- Command format: [15:12] opcode, [11:4] heading, [3:0] squares.
  - Opcodes: 4'h2 = move, 4'h3 = move with fanfare.
  - Headings: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- Move decode (bit -> dx,dy):
  - 0: +1,+2
  - 1: -1,+2
  - 2: -2,+1
  - 3: -2,-1
  - 4: -1,-2
  - 5: +1,-2
  - 6: +2,-1
  - 7: +2,+1
- Leg generation:
  - Vertical leg = opcode 2, heading N if dy>0 else S, squares=|dy|.
  - Horizontal leg = opcode 3, heading E if dx>0 else W, squares=|dx|.
  - move is not one-hot: cmd is undefined, but the FSM still advances.
- States: IDLE, VERT, WAIT_V, HORZ, WAIT_H.
- IDLE:
  - Mux selects UART: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy.
  - start_tour -> VERT, mv_indx<=0.
- VERT:
  - Mux selects tour; cmd=vertical leg, cmd_rdy=1.
  - clr_cmd_rdy -> WAIT_V.
- WAIT_V: cmd_rdy=0, cmd held. send_resp -> HORZ.
- HORZ:
  - cmd=horizontal leg, cmd_rdy=1.
  - clr_cmd_rdy -> WAIT_H.
- WAIT_H: on send_resp:
  - If mv_indx==NUM_MOVES-1 -> IDLE, mv_indx<=0.
  - Else mv_indx<=mv_indx+1 -> VERT.
- Tour-mode isolation:
  - In all non-IDLE states clr_cmd_rdy_UART=0; UART commands are held off, not dropped.
  - start_tour outside IDLE is ignored.
- resp:
  - 8'hA5 whenever a tour is in progress, except WAIT_H of the final move: 8'h5A.
  - 8'hA5 in IDLE (ack for UART commands).
- Simultaneous events:
  - clr_cmd_rdy and send_resp in the same cycle in VERT/HORZ: only clr_cmd_rdy acts; send_resp is ignored outside WAIT_x.
  - mv_indx changes only on the WAIT_H->VERT edge. move is sampled combinationally and is stable throughout a move.
- Latency: first tour cmd_rdy is asserted in the cycle after start_tour.

Decomposition:
- knights_pkg:
  - Opcode constants and the four heading constants.
  - Move-bit enum.
  - Response constants ACK_POS=8'hA5, DONE=8'h5A.
  - Typedef tour_state_t.
- Sub-module move_decode: combinational, one-hot move -> {vert_cmd, horz_cmd}. Keeps the FSM file small.

Test Plan:
- Idle passthrough: cmd_rdy_UART=1, cmd_UART=16'h2004, pulse clr_cmd_rdy -> cmd=16'h2004, cmd_rdy=1, clr_cmd_rdy_UART=1 in the same cycle.
- Single move decode: start_tour, move=8'h01 -> cmd=16'h2002 (N,2). After clr_cmd_rdy then send_resp -> cmd=16'h3BF1 (E,1 fanfare), mv_indx stays 0 until the second send_resp, then becomes 1.
- All eight moves: drive each one-hot value -> vertical/horizontal pairs match the table, e.g. bit 3 gives 16'h27F1 then 16'h33F2.
- Full tour: 24 move handshake sequences -> 48 commands, mv_indx 0..23, resp=8'h5A on the last WAIT_H, then return to IDLE with mv_indx=0.
- Isolation: cmd_rdy_UART=1 during the tour -> clr_cmd_rdy_UART stays 0, the tour cmd is unaffected, and the UART cmd is passed through once back in IDLE.
- Reset mid-tour: rst_n low at move 10 in WAIT_V -> next cycle state IDLE, mv_indx=0, cmd tracks cmd_UART.

Source files
------------

// File: rtl/knights_pkg.sv
// Shared constants and types for the knight's-tour command sequencer.
// Command layout is {opcode[3:0], heading[7:0], squares[3:0]}.
package knights_pkg;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    localparam logic [7:0] ACK_POS = 8'hA5;
    localparam logic [7:0] DONE    = 8'h5A;

    // Bit position in the one-hot move, named by (dx, dy)
    typedef enum logic [2:0] {
        MV_E1_N2 = 3'd0,
        MV_W1_N2 = 3'd1,
        MV_W2_N1 = 3'd2,
        MV_W2_S1 = 3'd3,
        MV_W1_S2 = 3'd4,
        MV_E1_S2 = 3'd5,
        MV_E2_S1 = 3'd6,
        MV_E2_N1 = 3'd7
    } move_bit_t;

    typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} tour_state_t;

    function automatic logic [15:0] mk_cmd(input logic [3:0] op, input logic [7:0] hdg,
                                           input logic [3:0] sq);
        return {op, hdg, sq};
    endfunction

endpackage

// File: rtl/move_decode.sv
// Combinational decode of a one-hot knight move into its two motion legs:
// vertical leg (plain move) then horizontal leg (move with fanfare).
module move_decode
    import knights_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd
);

    move_bit_t mv_bit;

    always_comb begin
        mv_bit = MV_E1_N2;
        for (int i = 0; i < 8; i++)
            if (move[i]) mv_bit = move_bit_t'(3'(i));
    end

    always_comb begin
        vert_cmd = mk_cmd(OP_MOVE, HDG_N, 4'd2);
        horz_cmd = mk_cmd(OP_FANFARE, HDG_E, 4'd1);
        case (mv_bit)
            MV_E1_N2: begin vert_cmd = mk_cmd(OP_MOVE, HDG_N, 4'd2); horz_cmd = mk_cmd(OP_FANFARE, HDG_E, 4'd1); end
            MV_W1_N2: begin vert_cmd = mk_cmd(OP_MOVE, HDG_N, 4'd2); horz_cmd = mk_cmd(OP_FANFARE, HDG_W, 4'd1); end
            MV_W2_N1: begin vert_cmd = mk_cmd(OP_MOVE, HDG_N, 4'd1); horz_cmd = mk_cmd(OP_FANFARE, HDG_W, 4'd2); end
            MV_W2_S1: begin vert_cmd = mk_cmd(OP_MOVE, HDG_S, 4'd1); horz_cmd = mk_cmd(OP_FANFARE, HDG_W, 4'd2); end
            MV_W1_S2: begin vert_cmd = mk_cmd(OP_MOVE, HDG_S, 4'd2); horz_cmd = mk_cmd(OP_FANFARE, HDG_W, 4'd1); end
            MV_E1_S2: begin vert_cmd = mk_cmd(OP_MOVE, HDG_S, 4'd2); horz_cmd = mk_cmd(OP_FANFARE, HDG_E, 4'd1); end
            MV_E2_S1: begin vert_cmd = mk_cmd(OP_MOVE, HDG_S, 4'd1); horz_cmd = mk_cmd(OP_FANFARE, HDG_E, 4'd2); end
            MV_E2_N1: begin vert_cmd = mk_cmd(OP_MOVE, HDG_N, 4'd1); horz_cmd = mk_cmd(OP_FANFARE, HDG_E, 4'd2); end
            default:  ;
        endcase
    end

endmodule

// File: rtl/tour_cmd.sv
// Muxes UART commands to cmd_proc while idle; during a tour, sequences each
// solved move as a vertical then horizontal command with handshakes.
module tour_cmd
    import knights_pkg::*;
#(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    output logic             clr_cmd_rdy_UART,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    output logic [7:0]       resp
);

    tour_state_t      state, nxt_state;
    logic [IDX_W-1:0] nxt_indx;
    logic [15:0]      vert_cmd, horz_cmd;
    logic             last_move;

    move_decode u_dec (
        .move     (move),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd)
    );

    assign last_move = (mv_indx == IDX_W'(NUM_MOVES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            mv_indx <= '0;
        end else begin
            state   <= nxt_state;
            mv_indx <= nxt_indx;
        end
    end

    always_comb begin
        nxt_state        = state;
        nxt_indx         = mv_indx;
        cmd              = vert_cmd;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = ACK_POS;
        case (state)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                if (start_tour) begin
                    nxt_state = VERT;
                    nxt_indx  = '0;
                end
            end
            VERT: begin
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) nxt_state = WAIT_V;
            end
            WAIT_V: begin
                if (send_resp) nxt_state = HORZ;
            end
            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) nxt_state = WAIT_H;
            end
            WAIT_H: begin
                cmd = horz_cmd;
                if (last_move) resp = DONE;
                if (send_resp) begin
                    if (last_move) begin
                        nxt_state = IDLE;
                        nxt_indx  = '0;
                    end else begin
                        nxt_state = VERT;
                        nxt_indx  = mv_indx + IDX_W'(1);
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

endmodule
